// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-path widths, state encoding and NOP constant
package riscv_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO holding PC-tagged instructions
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 42
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  // when full, a push is only legal because the head slot frees on the same edge
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch: issues imem reads, buffers PC-tagged results
module ifetch_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_stall,
  input  logic              flush,
  output logic              imem_en,
  output logic [ADDR_W-3:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              fetch_fault
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t              state;
  logic                      inflight;
  logic [ADDR_W-1:0]         pc_tag;
  logic [CW-1:0]             count;
  logic [CW:0]               occ;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [DATA_W+ADDR_W-1:0]  head;
  logic                      room;
  logic                      pop;
  logic                      issue;
  logic                      misaligned;
  logic                      resp_push;

  assign occ         = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign room        = fifo_full ? 1'b0 : (occ < (CW+1)'(DEPTH));
  assign instr_valid = !fifo_empty && (state != FAULT) && !flush;
  assign pop         = instr_valid && instr_ready;
  assign issue       = (state == RUN) && pc_valid && !flush && (room || pop);
  assign misaligned  = (pc_in[1:0] != 2'b00);
  assign imem_en     = issue;
  assign imem_addr   = pc_in[ADDR_W-1:2];
  assign pc_stall    = pc_valid && !issue;
  assign fetch_fault = (state == FAULT);
  // a misaligned request never sets inflight, so its read data is ignored
  assign resp_push   = inflight && !flush;
  assign {instr_out, instr_pc} = head;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W + ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (resp_push),
    .pop   (pop),
    .wdata ({imem_rdata, pc_tag}),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      inflight <= 1'b0;
      pc_tag   <= '0;
    end else begin
      inflight <= issue && !misaligned;
      if (issue) pc_tag <= pc_in;
      case (state)
        IDLE:    state <= RUN;
        RUN:     if (issue && misaligned) state <= FAULT;
        FAULT:   if (flush) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - table-driven bench with delivery scoreboard for ifetch_unit
module tb_ifetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pc_in;
  logic        pc_valid;
  logic        pc_stall;
  logic        flush;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_fault;

  ifetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc_in),
    .pc_valid    (pc_valid),
    .pc_stall    (pc_stall),
    .flush       (flush),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  // synchronous instruction memory, one-cycle latency
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'h00A00093 + 32'(imem_addr);
  end

  typedef struct {
    logic       rst, pcv;
    logic [9:0] pc;
    logic       fl, rdy;
    logic       e_en, e_st, e_val;
    logic [9:0] e_ipc;
    logic       e_flt;
  } vec_t;

  typedef struct {
    logic [9:0]  pc;
    logic [31:0] data;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input logic rst, pcv, input int pc, input logic fl, rdy, en, st, val,
                     input int ipc, input logic flt);
    vec_t v;
    v.rst = rst; v.pcv = pcv; v.pc = 10'(pc); v.fl = fl; v.rdy = rdy;
    v.e_en = en; v.e_st = st; v.e_val = val; v.e_ipc = 10'(ipc); v.e_flt = flt;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] mem_word(input logic [9:0] pc);
    return 32'h00A00093 + 32'(pc >> 2);
  endfunction

  task automatic deliver(input string tag);
    exp_t e;
    if (instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        chk({tag, " unexpected_delivery"}, {54'd0, instr_pc}, 64'h3ff_dead);
      end else begin
        e = sb.pop_front();
        chk({tag, " deliver_pc"}, {54'd0, instr_pc}, {54'd0, e.pc});
        chk({tag, " deliver_data"}, {32'd0, instr_out}, {32'd0, e.data});
      end
    end
  endtask

  initial begin
    exp_t e;
    // reset / idle
    add(1,0,  0,0,0, 0,0,0,  0,0);
    add(0,0,  0,0,0, 0,0,0,  0,0);
    // stream 0,4,8,12 with decode always ready
    add(0,1,  0,0,1, 1,0,0,  0,0);
    add(0,1,  4,0,1, 1,0,0,  0,0);
    add(0,1,  8,0,1, 1,0,1,  0,0);
    add(0,1, 12,0,1, 1,0,1,  4,0);
    add(0,0,  0,0,1, 0,0,1,  8,0);
    add(0,0,  0,0,1, 0,0,1, 12,0);
    // back-pressure: pc 8 waits, then issues alongside the pop
    add(0,1,  0,0,0, 1,0,0,  0,0);
    add(0,1,  4,0,0, 1,0,0,  0,0);
    add(0,1,  8,0,0, 0,1,1,  0,0);
    add(0,1,  8,0,0, 0,1,1,  0,0);
    add(0,1,  8,0,1, 1,0,1,  0,0);
    add(0,0,  0,0,1, 0,0,1,  4,0);
    add(0,0,  0,0,1, 0,0,1,  8,0);
    // full buffer: pop plus issue keeps occupancy at 2
    add(0,1, 20,0,0, 1,0,0,  0,0);
    add(0,1, 24,0,0, 1,0,0,  0,0);
    add(0,0,  0,0,0, 0,0,1, 20,0);
    add(0,1, 28,0,1, 1,0,1, 20,0);
    add(0,1, 32,0,0, 0,1,1, 24,0);
    add(0,0,  0,0,1, 0,0,1, 24,0);
    add(0,0,  0,0,1, 0,0,1, 28,0);
    // flush with 12 buffered and 16 in flight
    add(0,1, 12,0,0, 1,0,0,  0,0);
    add(0,1, 16,0,0, 1,0,0,  0,0);
    add(0,0,  0,1,0, 0,0,0,  0,0);
    add(0,1,800,0,1, 1,0,0,  0,0);
    add(0,0,  0,0,1, 0,0,0,  0,0);
    add(0,0,  0,0,1, 0,0,1,800,0);
    // misaligned 35 with 40 ahead of it, then flush and resume at 196
    add(0,1, 40,0,0, 1,0,0,  0,0);
    add(0,1, 35,0,0, 1,0,0,  0,0);
    add(0,1, 36,0,1, 0,1,0,  0,1);
    add(0,0,  0,0,1, 0,0,0,  0,1);
    add(0,0,  0,1,1, 0,0,0,  0,1);
    add(0,1,196,0,1, 1,0,0,  0,0);
    add(0,0,  0,0,1, 0,0,0,  0,0);
    add(0,0,  0,0,1, 0,0,1,196,0);
    // reset with one buffered and one in flight
    add(0,1,100,0,0, 1,0,0,  0,0);
    add(0,1,104,0,0, 1,0,0,  0,0);
    add(0,1,108,0,1, 1,0,1,100,0);
    add(1,0,  0,0,0, 0,0,1,104,0);
    add(0,0,  0,0,1, 0,0,0,  0,0);
    add(0,0,  0,0,1, 0,0,0,  0,0);
    add(0,1,  4,0,1, 1,0,0,  0,0);
    add(0,0,  0,0,1, 0,0,0,  0,0);
    add(0,0,  0,0,1, 0,0,1,  4,0);

    reset = 1'b1; pc_in = '0; pc_valid = 1'b0; flush = 1'b0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset instr_out", {32'd0, instr_out}, 64'd0);
    chk("reset instr_pc", {54'd0, instr_pc}, 64'd0);
    chk("reset valid", {63'd0, instr_valid}, 64'd0);
    chk("reset fault", {63'd0, fetch_fault}, 64'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      string tag;
      v = tbl[i];
      tag = $sformatf("r%0d", i);
      @(posedge clk); #1;
      reset = v.rst; pc_valid = v.pcv; pc_in = v.pc; flush = v.fl; instr_ready = v.rdy;
      @(negedge clk);
      chk({tag, " imem_en"}, {63'd0, imem_en}, {63'd0, v.e_en});
      chk({tag, " pc_stall"}, {63'd0, pc_stall}, {63'd0, v.e_st});
      chk({tag, " instr_valid"}, {63'd0, instr_valid}, {63'd0, v.e_val});
      chk({tag, " fetch_fault"}, {63'd0, fetch_fault}, {63'd0, v.e_flt});
      if (v.e_val) chk({tag, " instr_pc"}, {54'd0, instr_pc}, {54'd0, v.e_ipc});
      if (v.e_en) chk({tag, " imem_addr"}, {56'd0, imem_addr}, {56'd0, 8'(v.pc >> 2)});
      deliver(tag);
      if (v.e_en && v.pc[1:0] == 2'b00) begin
        e.pc = v.pc; e.data = mem_word(v.pc);
        sb.push_back(e);
      end
      if (v.fl || v.rst) sb.delete();
    end

    // fault, then flush and reset together: reset must win and land in IDLE
    @(posedge clk); #1;
    reset = 1'b0; flush = 1'b0; instr_ready = 1'b0; pc_valid = 1'b1; pc_in = 10'd2;
    @(negedge clk);
    chk("hs misaligned issue", {63'd0, imem_en}, 64'd1);
    @(posedge clk); #1;
    pc_valid = 1'b0;
    @(negedge clk);
    chk("hs fault set", {63'd0, fetch_fault}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; flush = 1'b0; pc_valid = 1'b1; pc_in = 10'd0;
    @(negedge clk);
    chk("hs reset_wins fault", {63'd0, fetch_fault}, 64'd0);
    chk("hs reset_wins idle_no_issue", {63'd0, imem_en}, 64'd0);
    chk("hs reset_wins stall", {63'd0, pc_stall}, 64'd1);
    pc_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("end valid", {63'd0, instr_valid}, 64'd0);
    chk("end scoreboard empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
